tmds_deserializer: RTL and testbench

Receive-side counterpart of the TMDS serializer. It shifts in one 10-bit TMDS channel bit-serially, LSB first, at the bit clock, and finds the word boundary by detecting TMDS control tokens during blanking. It then emits aligned 10-bit words with a valid strobe and a lock indication. It sits between the per-channel bit sampler and the TMDS decoder. It is used in loopback benches and on the receive path.

---
 rtl/tmds_deserializer.sv | 118 +++++++++++
 tb/tb_tmds_deserializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_deserializer.sv
// TMDS receive-channel deserializer: shifts in serial bits LSB first, aligns to the word
// boundary using control tokens seen during blanking, and emits aligned 10-bit words.
module tmds_deserializer #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_MAX  = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  output logic [9:0] data_o,
  output logic       valid_o,
  output logic       ctrl_o,
  output logic       locked_o
);

  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(LOCK_CNT - 1);
  localparam logic [EW-1:0] ERR_LAST = EW'(ERR_MAX - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [9:0]      sr_q;
  logic [3:0]      cnt_q, cnt_d;
  logic [HW-1:0]   hit_q, hit_d;
  logic [EW-1:0]   err_q, err_d;
  logic [9:0]      data_q;
  logic            valid_q, ctrl_q, locked_q;

  logic [9:0]      w;
  logic            tok, bnd, emit;

  // Window includes the bit arriving this cycle, so a word is complete on its last bit.
  assign w   = {data_i, sr_q[9:1]};
  assign tok = (w == 10'h354) | (w == 10'h0AB) | (w == 10'h154) | (w == 10'h2AB);
  assign bnd = (cnt_q == 4'd9);

  always_comb begin
    state_d = state_q;
    cnt_d   = bnd ? 4'd0 : cnt_q + 4'd1;
    hit_d   = hit_q;
    err_d   = err_q;
    emit    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (tok) begin
          cnt_d   = 4'd0;
          hit_d   = HW'(1);
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (bnd) begin
          if (!tok) begin
            state_d = SEARCH;
            hit_d   = '0;
          end else if (hit_q == HIT_LAST) begin
            state_d = LOCKED;
            err_d   = '0;
            emit    = 1'b1;
          end else begin
            hit_d = hit_q + HW'(1);
          end
        end
      end
      LOCKED: begin
        if (bnd) begin
          emit  = 1'b1;
          err_d = '0;
        end else if (tok) begin
          // Too many tokens off phase: resync directly on this one.
          if (err_q == ERR_LAST) begin
            state_d = VERIFY;
            cnt_d   = 4'd0;
            hit_d   = HW'(1);
            err_d   = '0;
          end else begin
            err_d = err_q + EW'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      cnt_q    <= '0;
      hit_q    <= '0;
      err_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ctrl_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= w;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
      valid_q  <= emit;
      locked_q <= (state_d == LOCKED);
      if (emit) begin
        data_q <= w;
        ctrl_q <= tok;
      end
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign ctrl_o   = ctrl_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Bench for tmds_deserializer: bit-level stimulus, a timeline-based reference model,
// and a scoreboard monitor that compares every emitted word and the lock flag.
module tb_tmds_deserializer;
  localparam int LOCK_CNT = 4;
  localparam int ERR_MAX  = 2;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic [9:0] data_o;
  logic       valid_o, ctrl_o, locked_o;

  tmds_deserializer #(.LOCK_CNT(LOCK_CNT), .ERR_MAX(ERR_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din),
    .data_o(data_o), .valid_o(valid_o), .ctrl_o(ctrl_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int when; logic [9:0] data; logic ctrl; } word_t;
  typedef struct { int when; logic lk; } lock_t;
  word_t wq[$];
  lock_t lq[$];

  // Reference model state: bit history plus the time of the last alignment anchor.
  logic hist[$];
  int   m_state, m_anchor, m_hits, m_errs;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit is_token(logic [9:0] v);
    return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
  endfunction

  function automatic void model_step(logic b, logic rn);
    logic [9:0] w;
    bit tok, bnd;
    int t;
    t = cyc + 1;
    if (!rn) begin
      hist.delete();
      repeat (10) hist.push_back(1'b0);
      m_state = M_SEARCH; m_anchor = t; m_hits = 0; m_errs = 0;
      lq.push_back(lock_t'{t, 1'b0});
      return;
    end
    hist.push_back(b);
    void'(hist.pop_front());
    for (int i = 0; i < 10; i++) w[i] = hist[i];
    tok = is_token(w);
    bnd = (t > m_anchor) && (((t - m_anchor) % 10) == 0);
    case (m_state)
      M_SEARCH: if (tok) begin m_anchor = t; m_hits = 1; m_state = M_VERIFY; end
      M_VERIFY: if (bnd) begin
        if (!tok) begin m_state = M_SEARCH; m_hits = 0; end
        else if (m_hits == LOCK_CNT - 1) begin
          m_state = M_LOCKED; m_errs = 0;
          wq.push_back(word_t'{t, w, tok});
        end else m_hits++;
      end
      default: begin
        if (bnd) begin
          m_errs = 0;
          wq.push_back(word_t'{t, w, tok});
        end else if (tok) begin
          if (m_errs == ERR_MAX - 1) begin
            m_state = M_VERIFY; m_anchor = t; m_hits = 1; m_errs = 0;
          end else m_errs++;
        end
      end
    endcase
    lq.push_back(lock_t'{t, logic'(m_state == M_LOCKED)});
  endfunction

  always @(negedge clk) begin : mon
    lock_t le;
    word_t we;
    while (lq.size() > 0 && lq[0].when <= cyc) begin
      le = lq.pop_front();
      if (le.when == cyc) chk("locked", locked_o, le.lk);
      else chk("lock_sched", cyc, le.when);
    end
    while (wq.size() > 0 && wq[0].when < cyc) begin
      chk("missed_word", cyc, wq[0].when);
      void'(wq.pop_front());
    end
    if (valid_o === 1'b1) begin
      if (wq.size() == 0) chk("spurious_valid", valid_o, 1'b0);
      else begin
        we = wq.pop_front();
        chk("valid_cycle", cyc, we.when);
        chk("data", data_o, we.data);
        chk("ctrl", ctrl_o, we.ctrl);
      end
    end
  end

  task automatic send_bit(logic b);
    din = b;
    model_step(b, rst_n);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(logic [9:0] v);
    for (int i = 0; i < 10; i++) send_bit(v[i]);
  endtask

  task automatic send_bits(logic [9:0] v, int lo, int hi);
    for (int i = lo; i <= hi; i++) send_bit(v[i]);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) send_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with random serial data
    do_reset(5);
    chk("rst_data", data_o, 10'h0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ctrl", ctrl_o, 1'b0);
    chk("rst_locked", locked_o, 1'b0);
    repeat (30) send_bit(1'b0);
    chk("zeros_no_lock", locked_o, 1'b0);

    // Acquisition on 10'h354
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    repeat (3) send_word(10'h354);
    chk("acq_not_yet", locked_o, 1'b0);
    send_word(10'h354);
    chk("acq_locked", locked_o, 1'b1);
    chk("acq_valid", valid_o, 1'b1);
    chk("acq_data", data_o, 10'h354);
    chk("acq_ctrl", ctrl_o, 1'b1);
    repeat (4) send_word(10'h354);

    // Data passthrough
    send_word(10'h1F0);
    chk("pt_data0", data_o, 10'h1F0);
    chk("pt_ctrl0", ctrl_o, 1'b0);
    send_word(10'h2A5);
    chk("pt_data1", data_o, 10'h2A5);
    send_word(10'h0AB);
    chk("pt_data2", data_o, 10'h0AB);
    chk("pt_ctrl2", ctrl_o, 1'b1);

    // Two off-phase tokens inside one word period: 354 then 0AB overlapping by two bits
    send_bit(1'b0);
    send_word(10'h354);
    send_bits(10'h0AB, 2, 8);
    chk("err_still_locked", locked_o, 1'b1);
    send_bits(10'h0AB, 9, 9);
    chk("err_lost_lock", locked_o, 1'b0);
    repeat (2) send_word(10'h354);
    chk("relock_not_yet", locked_o, 1'b0);
    send_word(10'h354);
    chk("relocked", locked_o, 1'b1);
    repeat (2) send_word(10'h354);

    // Bit slip, then continuous 10'h154
    send_bit(1'b0);
    repeat (12) send_word(10'h154);

    // Random words
    repeat (20) send_word(10'($urandom_range(0, 1023)));

    // Reset mid-stream discards alignment
    do_reset(2);
    chk("midrst_locked", locked_o, 1'b0);
    chk("midrst_valid", valid_o, 1'b0);
    chk("midrst_data", data_o, 10'h0);

    // Verify abort: two tokens, a data word, then four tokens
    repeat (15) send_bit(1'b0);
    repeat (2) send_word(10'h354);
    send_word(10'h1F0);
    chk("abort_no_lock", locked_o, 1'b0);
    repeat (3) send_word(10'h354);
    chk("abort_not_yet", locked_o, 1'b0);
    send_word(10'h354);
    chk("abort_locked", locked_o, 1'b1);

    // Loopback: serialized 2AB preamble then an incrementing counter
    do_reset(3);
    repeat (8) send_word(10'h2AB);
    chk("lb_locked", locked_o, 1'b1);
    for (int i = 0; i < 40; i++) send_word(10'(i));

    repeat (20) send_bit(1'b0);
    @(negedge clk);
    #1;
    chk("drain_words", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
